// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader_pkg                                            |
// | Description : Shared types and constants for the instruction-memory      |
// |               program loader (FSM state encoding, frame geometry).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package imem_loader_pkg;

  // Frame header is LEN_LO followed by LEN_HI.
  localparam int FRAME_HDR_BYTES = 2;
  // Instruction words are assembled from four little-endian bytes.
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : loader_word_packer                                         |
// | Description : Packs accepted data bytes into 32-bit little-endian words  |
// |               and keeps the running XOR of every data byte.              |
// | Ports       : clk, rst_n      - clock, async active-low reset            |
// |               clear_i         - restart packing for a new frame          |
// |               byte_vld_i      - data byte accepted this cycle            |
// |               byte_i          - the accepted byte                        |
// |               word_o          - assembled word {b3,b2,b1,b0} (valid with |
// |                                 word_done_o)                             |
// |               word_done_o     - 4th byte of a word accepted this cycle   |
// |               csum_o          - XOR of all data bytes since clear        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic [7:0]  csum_o
);

  localparam logic [1:0] c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q,   cnt_d;
  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is complete in the same cycle it arrives.
  logic [23:0] shift_q, shift_d;
  logic [7:0]  xor_q,   xor_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    xor_d   = xor_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
      xor_d   = 8'd0;
    end else if (byte_vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
      xor_d   = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      xor_q   <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
    end
  end

  assign word_o      = {byte_i, shift_q};
  assign word_done_o = byte_vld_i && !clear_i && (cnt_q == c_LAST_BYTE);
  assign csum_o      = xor_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader                                                |
// | Description : Loads a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes,|
// |               XOR checksum) into instruction memory and holds the CPU    |
// |               until an image has loaded with a good checksum.            |
// | Ports       : clk, rst_n             - clock, async active-low reset     |
// |               start_i                - begin a load (IDLE/DONE/ERR only) |
// |               rx_valid_i, rx_data_i  - byte stream in                    |
// |               rx_ready_o             - byte accepted when valid & ready  |
// |               mem_we_o/waddr_o/wdata_o - instruction memory write port   |
// |               cpu_hold_o             - pipeline stall request            |
// |               busy_o                 - load in progress                  |
// |               done_o, error_o        - sticky result of last load        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  // Largest legal word count: the whole memory.
  localparam logic [16:0] c_MAX_WORDS = 17'd1 << ADDR_WIDTH;

  loader_state_t state_q, state_d;

  logic [7:0]            len_lo_q;
  logic [15:0]           rem_q;        // words still to be written
  logic [ADDR_WIDTH-1:0] widx_q;       // index of the next word to write
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [31:0]           mem_wdata_q;

  logic        w_idle_like;
  logic        w_start;
  logic        w_accept;
  logic        w_data_byte;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_word_done;
  logic [7:0]  w_csum;

  assign w_idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERR);
  // Gated by rst_n so a start held during reset cannot raise cpu_hold.
  assign w_start     = start_i && w_idle_like && rst_n;
  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_data_byte = w_accept && (state_q == ST_DATA);
  assign w_len       = {rx_data_i, len_lo_q};

  loader_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (w_start),
    .byte_vld_i  (w_data_byte),
    .byte_i      (rx_data_i),
    .word_o      (w_word),
    .word_done_o (w_word_done),
    .csum_o      (w_csum)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          // Rejecting oversize images here means the word index can never
          // wrap, since no write has been issued yet.
          if ({1'b0, w_len} > c_MAX_WORDS) state_d = ST_ERR;
          else if (w_len == 16'd0)         state_d = ST_CSUM;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_done && (rem_q == 16'd1)) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_accept) state_d = (rx_data_i == w_csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; cpu_hold rises combinationally with an honoured start and is
  // then carried by the state until DONE.
  always_comb begin
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    error_o    = 1'b0;
    cpu_hold_o = w_start;
    case (state_q)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        cpu_hold_o = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      ST_ERR: begin
        error_o    = 1'b1;
        cpu_hold_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Length capture, word addressing and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q    <= 8'd0;
      rem_q       <= 16'd0;
      widx_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      mem_we_q <= w_word_done;
      if ((state_q == ST_LEN_LO) && w_accept) len_lo_q <= rx_data_i;
      if ((state_q == ST_LEN_HI) && w_accept) rem_q    <= w_len;
      if (w_start) begin
        widx_q <= '0;
      end else if (w_word_done) begin
        widx_q      <= widx_q + 1'b1;
        rem_q       <= rem_q - 16'd1;
        mem_waddr_q <= widx_q;
        mem_wdata_q <= w_word;
      end
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire
